// File: rtl/arlet6502_bus_arbiter_if.sv
// Bus bundle between the Arlet6502 arbiter and its CPU, DMA and memory sides.
// master: the arbiter itself; slave: the surrounding CPU/DMA/memory.
interface arlet6502_bus_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] cpu_a;
    logic [DATA_W-1:0] cpu_do;
    logic              cpu_we;
    logic [DATA_W-1:0] cpu_di;
    logic              cpu_rdy;
    logic              ext_rdy;
    logic              dma_req;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_we;
    logic              dma_gnt;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_rvalid;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  cpu_a, cpu_do, cpu_we, ext_rdy,
        input  dma_req, dma_addr, dma_wdata, dma_we,
        input  mem_rdata,
        output cpu_di, cpu_rdy, dma_gnt, dma_rdata, dma_rvalid,
        output mem_a, mem_wdata, mem_we
    );

    modport slave (
        output cpu_a, cpu_do, cpu_we, ext_rdy,
        output dma_req, dma_addr, dma_wdata, dma_we,
        output mem_rdata,
        input  cpu_di, cpu_rdy, dma_gnt, dma_rdata, dma_rvalid,
        input  mem_a, mem_wdata, mem_we
    );
endinterface

// File: rtl/arlet6502_bus_arbiter.sv
// CPU/DMA memory-port arbiter for the Arlet6502; stalls the CPU via RDY.
// Define ARB_BURST_LIMIT_EN to cap DMA bursts at MAX_BURST cycles.
module arlet6502_bus_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    arlet6502_bus_arbiter_if.master        bus
);
    typedef enum logic {
        CPU_OWN = 1'b0,
        DMA_OWN = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_cpu_rd_d;
    logic [DATA_W-1:0] r_di_hold;
    logic              r_dma_rvalid;

    logic w_dma;
    logic w_grant_ok;
    logic w_limit;
    logic w_release;

    if (MAX_BURST < 1) begin : g_bad_burst
        $error("MAX_BURST must be at least 1");
    end

    assign w_dma      = (r_state == DMA_OWN);
    // CPU writes ignore RDY, so a grant may only follow a read cycle.
    assign w_grant_ok = bus.dma_req & ~bus.cpu_we & bus.ext_rdy;

`ifdef ARB_BURST_LIMIT_EN
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_BURST - 1);

    logic [CNT_W-1:0] r_cnt;

    assign w_limit = w_dma & (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_dma) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end
`else
    assign w_limit = 1'b0;
`endif

    assign w_release = ~bus.dma_req | w_limit;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= CPU_OWN;
            r_cpu_rd_d   <= 1'b0;
            r_di_hold    <= '0;
            r_dma_rvalid <= 1'b0;
        end else begin
            r_cpu_rd_d   <= ~w_dma & ~bus.cpu_we;
            r_dma_rvalid <= w_dma & bus.dma_req & ~bus.dma_we;
            // Keep the CPU's last read so DI survives a DMA stall.
            if (r_cpu_rd_d) begin
                r_di_hold <= bus.mem_rdata;
            end
            unique case (r_state)
                CPU_OWN: if (w_grant_ok) r_state <= DMA_OWN;
                DMA_OWN: if (w_release)  r_state <= CPU_OWN;
            endcase
        end
    end

    assign bus.mem_a      = w_dma ? bus.dma_addr  : bus.cpu_a;
    assign bus.mem_wdata  = w_dma ? bus.dma_wdata : bus.cpu_do;
    assign bus.mem_we     = w_dma ? (bus.dma_we & bus.dma_req) : bus.cpu_we;
    assign bus.cpu_rdy    = ~w_dma & bus.ext_rdy;
    assign bus.dma_gnt    = w_dma;
    assign bus.cpu_di     = r_cpu_rd_d ? bus.mem_rdata : r_di_hold;
    assign bus.dma_rdata  = bus.mem_rdata;
    assign bus.dma_rvalid = r_dma_rvalid;
endmodule

// File: tb/tb_arlet6502_bus_arbiter.sv
// Scoreboard bench for arlet6502_bus_arbiter with a synchronous-read memory.
// Burst expectations follow ARB_BURST_LIMIT_EN with MAX_BURST=4.
module tb_arlet6502_bus_arbiter;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    arlet6502_bus_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    arlet6502_bus_arbiter #(
        .ADDR_W(16),
        .DATA_W(8),
        .MAX_BURST(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    logic [7:0] mem [0:65535];

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_a] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_a];
    end

    typedef struct {
        string       name;
        logic        gnt;
        logic        rdy;
        logic        rv;
        bit          cdi;
        logic [7:0]  di;
        bit          cm;
        logic [15:0] ma;
        logic        mwe;
        logic [7:0]  mwd;
    } exp_t;

    exp_t       eq[$];
    logic [7:0] rq[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(string n, logic [15:0] got, logic [15:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", n, got, want);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (eq.size() > 0) begin
            e = eq.pop_front();
            chk({e.name, ".gnt"}, 16'(bus.dma_gnt), 16'(e.gnt));
            chk({e.name, ".rdy"}, 16'(bus.cpu_rdy), 16'(e.rdy));
            chk({e.name, ".rvalid"}, 16'(bus.dma_rvalid), 16'(e.rv));
            if (e.cdi) chk({e.name, ".cpu_di"}, 16'(bus.cpu_di), 16'(e.di));
            if (e.cm) begin
                chk({e.name, ".mem_a"}, bus.mem_a, e.ma);
                chk({e.name, ".mem_we"}, 16'(bus.mem_we), 16'(e.mwe));
                if (e.mwe) chk({e.name, ".mem_wdata"}, 16'(bus.mem_wdata), 16'(e.mwd));
            end
        end
        if (bus.dma_rvalid === 1'b1) begin
            if (rq.size() > 0) begin
                chk("dma_rdata", 16'(bus.dma_rdata), 16'(rq.pop_front()));
            end else begin
                n_cmp++;
                n_err++;
                $display("FAIL dma_rvalid_unexpected: got 1, want 0");
            end
        end
    end

    function automatic exp_t ex(string n, logic g, logic r, logic v,
                                bit cdi = 0, logic [7:0] di = 0,
                                bit cm = 0, logic [15:0] ma = 0,
                                logic mwe = 0, logic [7:0] mwd = 0);
        exp_t e;
        e.name = n; e.gnt = g; e.rdy = r; e.rv = v;
        e.cdi = cdi; e.di = di;
        e.cm = cm; e.ma = ma; e.mwe = mwe; e.mwd = mwd;
        return e;
    endfunction

    task automatic tick(exp_t e);
        eq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drv(logic [15:0] a, logic [7:0] d, logic we, logic er,
                       logic req, logic [15:0] da, logic dwe, logic [7:0] dwd);
        bus.cpu_a     = a;
        bus.cpu_do    = d;
        bus.cpu_we    = we;
        bus.ext_rdy   = er;
        bus.dma_req   = req;
        bus.dma_addr  = da;
        bus.dma_we    = dwe;
        bus.dma_wdata = dwd;
    endtask

    logic       g_pat  [12];
    logic       v_pat  [12];
    logic [7:0] di_pat [12];
    logic [15:0] ca;
    logic        req;

    initial begin
`ifdef ARB_BURST_LIMIT_EN
        g_pat  = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 0};
        v_pat  = '{0, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        di_pat = '{8'h00, 8'h4C, 8'h4C, 8'h4C, 8'h4C, 8'h4C,
                   8'h4D, 8'h4D, 8'h4D, 8'h4D, 8'h4D, 8'h4E};
`else
        g_pat  = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        v_pat  = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        di_pat = '{8'h00, 8'h4C, 8'h4C, 8'h4C, 8'h4C, 8'h4C,
                   8'h4C, 8'h4C, 8'h4C, 8'h4C, 8'h4C, 8'h4C};
`endif
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0200] = 8'h5A;
        mem[16'h0201] = 8'hA5;
        mem[16'h0202] = 8'h3C;
        mem[16'h8000] = 8'h11;
        mem[16'h8001] = 8'h22;
        mem[16'h8002] = 8'h33;
        mem[16'h0400] = 8'h4C;
        mem[16'h0401] = 8'h4D;
        mem[16'h0402] = 8'h4E;
        mem[16'hA000] = 8'hAA;
        for (int i = 0; i < 12; i++) mem[16'h9000 + 16'(i)] = 8'h90 + 8'(i);

        reset = 1'b0;
        drv(16'h0000, 8'h00, 0, 1, 1, 16'h8000, 0, 8'h00);
        @(posedge clk);
        #1;
        // reset held with dma_req high
        tick(ex("rst0", 0, 1, 0, 1, 8'h00));
        bus.ext_rdy = 1'b0;
        tick(ex("rst1", 0, 0, 0, 1, 8'h00));
        reset = 1'b1;

        // CPU read of 0x0200 overlapped by a 3-read DMA burst
        drv(16'h0200, 8'h00, 0, 1, 1, 16'h8000, 0, 8'h00);
        tick(ex("A", 0, 1, 0, 1, 8'h00, 1, 16'h0200, 0));
        drv(16'h0201, 8'h00, 0, 1, 1, 16'h8000, 0, 8'h00);
        rq.push_back(8'h11);
        tick(ex("B", 1, 0, 0, 1, 8'h5A, 1, 16'h8000, 0));
        bus.dma_addr = 16'h8001;
        rq.push_back(8'h22);
        tick(ex("C", 1, 0, 1, 1, 8'h5A, 1, 16'h8001, 0));
        bus.dma_addr = 16'h8002;
        rq.push_back(8'h33);
        tick(ex("D", 1, 0, 1, 1, 8'h5A, 1, 16'h8002, 0));
        bus.dma_req = 1'b0;
        tick(ex("E", 1, 0, 1, 1, 8'h5A, 1, 16'h8002, 0));
        tick(ex("F", 0, 1, 0, 1, 8'h5A, 1, 16'h0201, 0));
        bus.cpu_a = 16'h0202;
        tick(ex("G", 0, 1, 0, 1, 8'hA5, 1, 16'h0202, 0));

        // DMA request during CPU writes is deferred
        drv(16'h0300, 8'hC3, 1, 1, 1, 16'h8003, 1, 8'h77);
        tick(ex("H", 0, 1, 0, 1, 8'h3C, 1, 16'h0300, 1, 8'hC3));
        drv(16'h0301, 8'hC4, 1, 1, 1, 16'h8003, 1, 8'h77);
        tick(ex("I", 0, 1, 0, 0, 8'h00, 1, 16'h0301, 1, 8'hC4));
        drv(16'h0302, 8'h00, 0, 1, 1, 16'h8003, 1, 8'h77);
        tick(ex("J", 0, 1, 0, 1, 8'h3C, 1, 16'h0302, 0));
        drv(16'h0303, 8'h00, 0, 1, 1, 16'h8003, 1, 8'h77);
        tick(ex("K", 1, 0, 0, 0, 8'h00, 1, 16'h8003, 1, 8'h77));
        bus.dma_req = 1'b0;
        tick(ex("L", 1, 0, 0, 0, 8'h00, 1, 16'h8003, 0));
        tick(ex("M", 0, 1, 0, 0, 8'h00, 1, 16'h0303, 0));

        // dma_req held 10 cycles
        ca = 16'h0400;
        for (int i = 0; i < 12; i++) begin
            req = (i < 10);
            drv(ca, 8'h00, 0, 1, req, 16'h9000 + 16'(i), 0, 8'h00);
            if (g_pat[i] && req) rq.push_back(8'h90 + 8'(i));
            tick(ex($sformatf("P%0d", i), g_pat[i], !g_pat[i], v_pat[i],
                    i > 0, di_pat[i], 1,
                    g_pat[i] ? 16'h9000 + 16'(i) : ca, 0));
            if (!g_pat[i]) ca = ca + 16'h0001;
        end

        // reset in the second cycle of a DMA burst
        drv(ca, 8'h00, 0, 1, 1, 16'hA000, 0, 8'h00);
        tick(ex("S0", 0, 1, 0));
        rq.push_back(8'hAA);
        tick(ex("S1", 1, 0, 0, 0, 8'h00, 1, 16'hA000, 0));
        reset = 1'b0;
        tick(ex("S2", 1, 0, 1));
        reset = 1'b1;
        bus.dma_req = 1'b0;
        tick(ex("S3", 0, 1, 0, 1, 8'h00));

        // request deferred while ext_rdy is low
        drv(ca, 8'h00, 0, 0, 1, 16'hA001, 0, 8'h00);
        tick(ex("T0", 0, 0, 0));
        bus.ext_rdy = 1'b1;
        tick(ex("T1", 0, 1, 0));
        bus.dma_req = 1'b0;
        tick(ex("T2", 1, 0, 0, 0, 8'h00, 1, 16'hA001, 0));
        tick(ex("T3", 0, 1, 0));

        repeat (3) @(posedge clk);
        #1;
        chk("exp_queue_left", 16'(eq.size()), 16'd0);
        chk("rdata_queue_left", 16'(rq.size()), 16'd0);
        chk("mem_0300", 16'(mem[16'h0300]), 16'h00C3);
        chk("mem_0301", 16'(mem[16'h0301]), 16'h00C4);
        chk("mem_8003", 16'(mem[16'h8003]), 16'h0077);
        chk("mem_8002", 16'(mem[16'h8002]), 16'h0033);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
